midi_tx_sched: RTL and testbench
================================

# midi_tx_sched

Round-robin scheduler that shares one MIDI byte transmitter among `N_REQ` message sources, such as button and pot front-ends. It accepts whole MIDI messages (status plus up to two data bytes) over per-requester valid/ready handshakes. It serialises each accepted message into the downstream UART byte stream (31250 baud framing is done downstream) using a byte-level valid/ready handshake. Messages from different requesters are never interleaved.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters, 2..8.
- `IDW`, default `$clog2(N_REQ)`: width of `grant_id`.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  N_REQ  requester i has a message.
- `req_ready`  out  N_REQ  one-cycle accept pulse to requester i.
- `req_status`  in  8*N_REQ  status byte, slice i.
- `req_data1`  in  8*N_REQ  first data byte, slice i.
- `req_data2`  in  8*N_REQ  second data byte, slice i.
- `tx_valid`  out  1  `tx_byte` is valid.
- `tx_ready`  in  1  transmitter takes the byte.
- `tx_byte`  out  8  byte to the MIDI UART.
- `busy`  out  1  a message is in flight.
- `grant_id`  out  IDW  index of the last accepted requester.
- `drop`  out  1  one-cycle pulse when an accepted message is discarded.

## Operation
- FSM states: IDLE, SEND_ST, SEND_D1, SEND_D2.
- **IDLE, no `req_valid`:** stay in IDLE.
- **IDLE, any `req_valid`:**
  - Select the winner round-robin, starting at `rr_ptr`.
  - Assert `req_ready[winner]` in that cycle and capture the winner's three bytes.
  - Set `grant_id`, and set `rr_ptr` = winner+1 mod `N_REQ`.
- **Message length, decoded from the captured status:**
  - 0x80–0xBF, 0xE0–0xEF: 3 bytes.
  - 0xC0–0xDF: 2 bytes (data2 ignored).
  - 0xF0–0xFF: 1 byte (multi-byte system messages are unsupported).
  - Status bit7 = 0: message is dropped. Pulse `drop`, send nothing, stay in IDLE.
- **Next state after capture:** SEND_ST, or SEND_D1 when running status suppresses the status byte (see Configuration).
- **Byte phases:** each SEND_* state drives `tx_valid`=1 with its byte and advances only on `tx_valid && tx_ready`. After the last byte, go to IDLE.
- **Handshake rules:**
  - Once `tx_valid` rises, it and `tx_byte` hold stable until the handshake.
  - A requester may drop `req_valid` before it is accepted; the scheduler has no memory of it.
  - Inputs are sampled only in the accept cycle.
- **`busy`:** 1 whenever the state is not IDLE.

## Timing
- **Reset values** (asynchronous, effective immediately on `rst` high):
  - State IDLE.
  - `req_ready`=0, `tx_valid`=0, `tx_byte`=0x00, `busy`=0, `grant_id`=0, `drop`=0.
  - `rr_ptr`=0, last-status register = 0x00.
- **Reset mid-message:** the in-flight message is lost; no partial continuation after release.
- **Accept to first byte:** accept in cycle T; `tx_valid`=1 in T+1.
- **Last byte to next accept:** last byte handshakes in T; earliest next accept is T+1. One bubble cycle is allowed.
- **`tx_ready` held high:** a 3-byte message occupies 3 consecutive cycles of `tx_valid`.
- **Simultaneous requests:** exactly one `req_ready` bit is high per cycle, never in a non-IDLE state.
- **`rr_ptr` wrap:** wraps from `N_REQ-1` to 0.
- **Fairness:** with all requesters permanently valid, each is served once per `N_REQ` messages.

## Configuration
- `MIDI_RUNNING_STATUS_EN` defined:
  - A last-status register records every transmitted status byte in 0x80–0xEF.
  - A new message with a status equal to the register and in that range skips SEND_ST.
  - Any status 0xF0–0xF7 clears the register to 0x00.
  - Real-time 0xF8–0xFF leaves the register unchanged.
  - Dropped messages leave the register unchanged.
- `MIDI_RUNNING_STATUS_EN` undefined: every message sends its status byte, and the register is absent.

## Structure
- **Package `midi_pkg`:**
  - Message struct (status, data1, data2).
  - FSM state enum.
  - Status class constants: NOTE_OFF 0x80, NOTE_ON 0x90, PROG_CHG 0xC0, CHAN_PRESS 0xD0, SYS_BASE 0xF0, RT_BASE 0xF8.
  - Function `midi_msg_len(status)` returning 0..3, where 0 means drop.
- **Sub-module `midi_rr_arb`:**
  - Parameterised round-robin arbiter with inputs `req` and `advance` and outputs one-hot `gnt` plus `gnt_idx`.
  - Holds `rr_ptr` internally.

## Test plan
1. Req 0 sends 0x90/0x3C/0x64, `tx_ready`=1 → bytes 90 3C 64, one `req_ready[0]` pulse, `busy` high for 3 cycles.
2. All four requesters held valid with distinct notes → grant order 0,1,2,3,0; `grant_id` tracks it.
3. Req 1 sends 0xC1/0x05, then 0xF8 → bytes C1 05, then F8 alone; 0x3C status → `drop` pulse, no bytes.
4. `tx_ready` held low for 10 cycles mid-message → `tx_valid`=1 and `tx_byte`=0x3C stable throughout; the next byte follows the handshake.
5. Two 0x90 messages (3C 64, then 3C 00):
   - Macro defined → 90 3C 64 3C 00.
   - Macro defined, with 0xF2 sent between them → second message sends its status again.
   - Macro undefined → 6 bytes.
6. `rst` pulsed during SEND_D1 → `tx_valid`=0 immediately; after release, the same message resent begins with its status byte.

Source files
------------

// File: rtl/midi_tx_sched_pkg.sv
// Shared types, status-class constants and length decode for the MIDI transmit scheduler.
package midi_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND_ST,
        S_SEND_D1,
        S_SEND_D2
    } state_t;

    typedef struct packed {
        logic [7:0] status;
        logic [7:0] data1;
        logic [7:0] data2;
    } midi_msg_t;

    localparam logic [7:0] NOTE_OFF   = 8'h80;
    localparam logic [7:0] NOTE_ON    = 8'h90;
    localparam logic [7:0] PROG_CHG   = 8'hC0;
    localparam logic [7:0] CHAN_PRESS = 8'hD0;
    localparam logic [7:0] SYS_BASE   = 8'hF0;
    localparam logic [7:0] RT_BASE    = 8'hF8;

    // Bytes on the wire for a status byte; 0 marks a message that must be dropped.
    function automatic logic [1:0] midi_msg_len(input logic [7:0] status);
        logic [1:0] len;
        case (status[7:4])
            NOTE_OFF[7:4], NOTE_ON[7:4], 4'hA, 4'hB, 4'hE: len = 2'd3;
            PROG_CHG[7:4], CHAN_PRESS[7:4]:                len = 2'd2;
            SYS_BASE[7:4]:                                 len = 2'd1;
            default:                                       len = 2'd0;
        endcase
        return len;
    endfunction

    function automatic logic midi_is_channel(input logic [7:0] status);
        return (status >= NOTE_OFF) && (status < SYS_BASE);
    endfunction

    function automatic logic midi_is_realtime(input logic [7:0] status);
        return status >= RT_BASE;
    endfunction

endpackage

// File: rtl/midi_tx_sched_if.sv
// Requester message handshakes plus the downstream byte handshake of the MIDI scheduler.
interface midi_tx_sched_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ-1:0]   req_ready;
    logic [8*N_REQ-1:0] req_status;
    logic [8*N_REQ-1:0] req_data1;
    logic [8*N_REQ-1:0] req_data2;
    logic               tx_valid;
    logic               tx_ready;
    logic [7:0]         tx_byte;

    // Master: the message sources and the UART sink.
    modport master (
        output req_valid, req_status, req_data1, req_data2, tx_ready,
        input  req_ready, tx_valid, tx_byte
    );

    // Slave: the scheduler itself.
    modport slave (
        input  req_valid, req_status, req_data1, req_data2, tx_ready,
        output req_ready, tx_valid, tx_byte
    );
endinterface

// File: rtl/midi_tx_sched_rr_arb.sv
// Round-robin arbiter: searches from rr_ptr, pointer moves past the winner on advance.
module midi_rr_arb #(
    parameter int N_REQ = 4,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             advance,
    output logic [N_REQ-1:0] gnt,
    output logic [IDW-1:0]   gnt_idx
);

    logic [IDW-1:0] r_ptr;

    always_comb begin
        logic found;
        // NOTE: every output gets a default before the search so no latch is inferred.
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            int j;
            j = int'(r_ptr) + i;
            if (j >= N_REQ) j = j - N_REQ;
            if (!found && req[j]) begin
                found   = 1'b1;
                gnt[j]  = 1'b1;
                gnt_idx = IDW'(j);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (advance) begin
            r_ptr <= (gnt_idx == IDW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/midi_tx_sched.sv
// Shares one MIDI byte transmitter among N_REQ message sources, one whole message at a time.
// Optional running status: define MIDI_RUNNING_STATUS_EN.
module midi_tx_sched
    import midi_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic           clk,
    input  logic           rst,
    midi_tx_sched_if.slave bus,
    output logic           busy,
    output logic [IDW-1:0] grant_id,
    output logic           drop
);

    state_t           r_state;
    logic [1:0]       r_len;
    logic [7:0]       r_data1;
    logic [7:0]       r_data2;
    logic             r_tx_valid;
    logic [7:0]       r_tx_byte;
    logic [IDW-1:0]   r_grant;
    logic             r_drop;

    logic [N_REQ-1:0] w_gnt;
    logic [IDW-1:0]   w_gnt_idx;
    logic             w_accept;
    midi_msg_t        w_msg;
    logic [1:0]       w_len;
    logic             w_skip;
    logic             w_hs;

    // Requests are only looked at in IDLE and never while reset is asserted.
    assign w_accept      = (r_state == S_IDLE) && !rst && (|bus.req_valid);
    assign bus.req_ready = w_accept ? w_gnt : '0;
    assign w_hs          = r_tx_valid && bus.tx_ready;

    midi_rr_arb #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (bus.req_valid),
        .advance (w_accept),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx)
    );

    always_comb begin
        w_msg.status = bus.req_status[8*w_gnt_idx +: 8];
        w_msg.data1  = bus.req_data1[8*w_gnt_idx +: 8];
        w_msg.data2  = bus.req_data2[8*w_gnt_idx +: 8];
    end

    assign w_len = midi_msg_len(w_msg.status);

`ifdef MIDI_RUNNING_STATUS_EN
    logic [7:0] r_last_status;

    assign w_skip = (w_msg.status == r_last_status) && midi_is_channel(w_msg.status);

    // Updated at accept time: the byte is either sent now or already equals the register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_status <= 8'h00;
        end else if (w_accept && (w_len != 2'd0)) begin
            if (midi_is_channel(w_msg.status)) begin
                r_last_status <= w_msg.status;
            end else if (!midi_is_realtime(w_msg.status)) begin
                r_last_status <= 8'h00;
            end
        end
    end
`else
    assign w_skip = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_len      <= 2'd0;
            r_data1    <= 8'h00;
            r_data2    <= 8'h00;
            r_tx_valid <= 1'b0;
            r_tx_byte  <= 8'h00;
            r_grant    <= '0;
            r_drop     <= 1'b0;
        end else begin
            r_drop <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_len   <= w_len;
                        r_data1 <= w_msg.data1;
                        r_data2 <= w_msg.data2;
                        r_grant <= w_gnt_idx;
                        if (w_len == 2'd0) begin
                            r_drop <= 1'b1;
                        end else if (w_skip) begin
                            r_state    <= S_SEND_D1;
                            r_tx_valid <= 1'b1;
                            r_tx_byte  <= w_msg.data1;
                        end else begin
                            r_state    <= S_SEND_ST;
                            r_tx_valid <= 1'b1;
                            r_tx_byte  <= w_msg.status;
                        end
                    end
                end
                S_SEND_ST: begin
                    if (w_hs) begin
                        if (r_len == 2'd1) begin
                            r_state    <= S_IDLE;
                            r_tx_valid <= 1'b0;
                        end else begin
                            r_state   <= S_SEND_D1;
                            r_tx_byte <= r_data1;
                        end
                    end
                end
                S_SEND_D1: begin
                    if (w_hs) begin
                        if (r_len == 2'd3) begin
                            r_state   <= S_SEND_D2;
                            r_tx_byte <= r_data2;
                        end else begin
                            r_state    <= S_IDLE;
                            r_tx_valid <= 1'b0;
                        end
                    end
                end
                S_SEND_D2: begin
                    if (w_hs) begin
                        r_state    <= S_IDLE;
                        r_tx_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_tx_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.tx_valid = r_tx_valid;
    assign bus.tx_byte  = r_tx_byte;
    assign busy         = (r_state != S_IDLE);
    assign grant_id     = r_grant;
    assign drop         = r_drop;

endmodule

// File: tb/tb_midi_tx_sched.sv
// Self-checking bench for midi_tx_sched: queue-based message model checked every cycle, plus literal byte logs.
module tb_midi_tx_sched;
    import midi_pkg::*;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       busy;
    logic [1:0] grant_id;
    logic       drop;

    midi_tx_sched_if #(.N_REQ(N)) bus ();

    midi_tx_sched #(.N_REQ(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .busy     (busy),
        .grant_id (grant_id),
        .drop     (drop)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Message sources: one queue per requester, presented until accepted.
    midi_msg_t src_q [N][$];

    initial begin
        bus.req_valid  = '0;
        bus.req_status = '0;
        bus.req_data1  = '0;
        bus.req_data2  = '0;
        forever begin
            @(posedge clk);
            #2;
            for (int i = 0; i < N; i++) begin
                if (src_q[i].size() > 0) begin
                    bus.req_valid[i]         = 1'b1;
                    bus.req_status[8*i +: 8] = src_q[i][0].status;
                    bus.req_data1[8*i +: 8]  = src_q[i][0].data1;
                    bus.req_data2[8*i +: 8]  = src_q[i][0].data2;
                end else begin
                    bus.req_valid[i]         = 1'b0;
                    bus.req_status[8*i +: 8] = 8'h00;
                    bus.req_data1[8*i +: 8]  = 8'h00;
                    bus.req_data2[8*i +: 8]  = 8'h00;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                if (bus.req_ready[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            end
        end
    end

    // Behavioural model: expected wire bytes, arbitration pointer, running status.
    logic [7:0] m_bytes[$];
    int         m_ptr  = 0;
    logic [1:0] m_grant = 2'd0;
    logic       m_drop = 1'b0;
    logic [7:0] m_last = 8'h00;

    logic [7:0] q_tx_log[$];
    int         q_acc_log[$];
    int         drop_cnt = 0;
    int         busy_cnt = 0;

    function automatic int model_len(input logic [7:0] s);
        if (s < 8'h80) return 0;
        if (s >= 8'hF0) return 1;
        if (s >= 8'hC0 && s <= 8'hDF) return 2;
        return 3;
    endfunction

    always @(negedge clk) begin
        logic       exp_busy;
        logic [3:0] exp_rdy;
        int         win;
        int         len;
        logic       skip;
        logic [7:0] s, d1, d2;
        if (rst) begin
            check("rst_tx_valid", bus.tx_valid, 1'b0);
            check("rst_tx_byte", bus.tx_byte, 8'h00);
            check("rst_busy", busy, 1'b0);
            check("rst_grant_id", grant_id, 2'd0);
            check("rst_drop", drop, 1'b0);
            check("rst_req_ready", bus.req_ready, 4'h0);
            m_bytes.delete();
            m_ptr   = 0;
            m_grant = 2'd0;
            m_drop  = 1'b0;
            m_last  = 8'h00;
        end else begin
            exp_busy = (m_bytes.size() != 0);
            check("busy", busy, exp_busy);
            check("tx_valid", bus.tx_valid, exp_busy);
            if (exp_busy) check("tx_byte", bus.tx_byte, m_bytes[0]);
            exp_rdy = 4'h0;
            win     = -1;
            if (!exp_busy) begin
                for (int k = 0; k < N; k++) begin
                    int j;
                    j = (m_ptr + k) % N;
                    if (win < 0 && bus.req_valid[j]) win = j;
                end
            end
            if (win >= 0) exp_rdy[win] = 1'b1;
            check("req_ready", bus.req_ready, exp_rdy);
            check("grant_id", grant_id, m_grant);
            check("drop", drop, m_drop);

            if (bus.tx_valid && bus.tx_ready) q_tx_log.push_back(bus.tx_byte);
            for (int i = 0; i < N; i++) if (bus.req_ready[i]) q_acc_log.push_back(i);
            if (drop) drop_cnt++;
            if (busy) busy_cnt++;

            m_drop = 1'b0;
            if (exp_busy && bus.tx_ready) void'(m_bytes.pop_front());
            if (win >= 0) begin
                s       = bus.req_status[8*win +: 8];
                d1      = bus.req_data1[8*win +: 8];
                d2      = bus.req_data2[8*win +: 8];
                m_grant = win[1:0];
                m_ptr   = (win + 1) % N;
                len     = model_len(s);
                skip    = 1'b0;
                if (len == 0) begin
                    m_drop = 1'b1;
                end else begin
`ifdef MIDI_RUNNING_STATUS_EN
                    if (s >= 8'h80 && s <= 8'hEF) begin
                        skip   = (s == m_last);
                        m_last = s;
                    end else if (s >= 8'hF0 && s <= 8'hF7) begin
                        m_last = 8'h00;
                    end
`endif
                    if (!skip) m_bytes.push_back(s);
                    if (len >= 2) m_bytes.push_back(d1);
                    if (len == 3) m_bytes.push_back(d2);
                end
            end
        end
    end

    logic [7:0] exp_log[$];
    int         exp_acc[$];

    task automatic clear_logs();
        q_tx_log.delete();
        q_acc_log.delete();
        drop_cnt = 0;
        busy_cnt = 0;
    endtask

    task automatic check_tx_log(input string name);
        check({name, "_count"}, q_tx_log.size(), exp_log.size());
        for (int i = 0; i < exp_log.size() && i < q_tx_log.size(); i++)
            check(name, q_tx_log[i], exp_log[i]);
    endtask

    task automatic check_acc_log(input string name);
        check({name, "_count"}, q_acc_log.size(), exp_acc.size());
        for (int i = 0; i < exp_acc.size() && i < q_acc_log.size(); i++)
            check(name, q_acc_log[i], exp_acc[i]);
    endtask

    task automatic push(input int r, input logic [7:0] st, input logic [7:0] a, input logic [7:0] b);
        midi_msg_t m;
        m.status = st;
        m.data1  = a;
        m.data2  = b;
        src_q[r].push_back(m);
    endtask

    task automatic wait_idle(input string name);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (src_q[0].size() == 0 && src_q[1].size() == 0 && src_q[2].size() == 0 &&
                src_q[3].size() == 0 && !busy && !bus.tx_valid) begin
                done = 1'b1;
                break;
            end
        end
        repeat (2) @(posedge clk);
        #1;
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: still busy=%0b, required idle", name, busy);
        end
    endtask

    task automatic wait_tx_valid(input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (bus.tx_valid) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: tx_valid=0, required 1", name);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 rst = 1'b1;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
    endtask

    initial begin
        bus.tx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;

        // 1: single three-byte note-on
        @(posedge clk);
        #1;
        clear_logs();
        push(0, NOTE_ON, 8'h3C, 8'h64);
        wait_idle("t1");
        exp_log = '{8'h90, 8'h3C, 8'h64};
        check_tx_log("t1_bytes");
        exp_acc = '{0};
        check_acc_log("t1_accept");
        check("t1_busy_cycles", busy_cnt, 3);

        // 2: all four requesters valid
        do_reset();
        #1;
        clear_logs();
        push(0, 8'h90, 8'h3C, 8'h40);
        push(0, 8'h90, 8'h48, 8'h40);
        push(1, 8'h91, 8'h3E, 8'h40);
        push(2, 8'h92, 8'h40, 8'h40);
        push(3, 8'h93, 8'h43, 8'h40);
        wait_idle("t2");
        exp_acc = '{0, 1, 2, 3, 0};
        check_acc_log("t2_order");
        check("t2_byte_count", q_tx_log.size(), 15);

        // 3: two-byte, real-time and dropped messages
        clear_logs();
        push(1, 8'hC1, 8'h05, 8'h77);
        push(1, 8'hF8, 8'h00, 8'h00);
        push(2, 8'h3C, 8'h11, 8'h22);
        wait_idle("t3");
        exp_log = '{8'hC1, 8'h05, 8'hF8};
        check_tx_log("t3_bytes");
        check("t3_drops", drop_cnt, 1);

        // 4: back-pressure on data1
        clear_logs();
        bus.tx_ready = 1'b0;
        push(0, 8'h90, 8'h3C, 8'h64);
        wait_tx_valid("t4");
        bus.tx_ready = 1'b1;
        @(posedge clk);
        #1 bus.tx_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("t4_hold_valid", bus.tx_valid, 1'b1);
            check("t4_hold_byte", bus.tx_byte, 8'h3C);
            @(posedge clk);
            #1;
        end
        bus.tx_ready = 1'b1;
        wait_idle("t4");
        exp_log = '{8'h90, 8'h3C, 8'h64};
        check_tx_log("t4_bytes");

        // 5a: repeated note-on status
        do_reset();
        #1;
        clear_logs();
        push(0, 8'h90, 8'h3C, 8'h64);
        push(0, 8'h90, 8'h3C, 8'h00);
        wait_idle("t5a");
`ifdef MIDI_RUNNING_STATUS_EN
        exp_log = '{8'h90, 8'h3C, 8'h64, 8'h3C, 8'h00};
`else
        exp_log = '{8'h90, 8'h3C, 8'h64, 8'h90, 8'h3C, 8'h00};
`endif
        check_tx_log("t5a_bytes");

        // 5b: system common message between them cancels running status
        do_reset();
        #1;
        clear_logs();
        push(0, 8'h90, 8'h3C, 8'h64);
        push(0, 8'hF2, 8'h00, 8'h00);
        push(0, 8'h90, 8'h3C, 8'h00);
        wait_idle("t5b");
        exp_log = '{8'h90, 8'h3C, 8'h64, 8'hF2, 8'h90, 8'h3C, 8'h00};
        check_tx_log("t5b_bytes");

        // 6: reset while data1 is on the wire
        clear_logs();
        bus.tx_ready = 1'b0;
        push(0, 8'h90, 8'h3C, 8'h64);
        wait_tx_valid("t6");
        bus.tx_ready = 1'b1;
        @(posedge clk);
        #1 bus.tx_ready = 1'b0;
        check("t6_in_d1", bus.tx_byte, 8'h3C);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("t6_async_tx_valid", bus.tx_valid, 1'b0);
        check("t6_async_busy", busy, 1'b0);
        @(posedge clk);
        #3 rst = 1'b0;
        clear_logs();
        @(posedge clk);
        #1;
        bus.tx_ready = 1'b1;
        push(0, 8'h90, 8'h3C, 8'h64);
        wait_idle("t6");
        exp_log = '{8'h90, 8'h3C, 8'h64};
        check_tx_log("t6_resend");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
